// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage core: data-memory handshakes, load-use bubbles,
// taken-branch squash and a lost-cycle counter. Outputs are combinational from state + inputs.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_take_branch,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        mem_fault,
  output logic [31:0] stall_cycles
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;

  logic mem_op;
  logic in_wait;
  logic access_done;
  logic timeout;
  logic mem_stall;
  logic raw_hit;
  logic load_use;
  logic branch;

  always_comb begin
    mem_op      = ex_valid & (ex_is_load | ex_is_store);
    in_wait     = (state_q == MEM_WAIT);
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    access_done = 1'b0;
    timeout     = 1'b0;
    mem_stall   = 1'b0;
    raw_hit     = 1'b0;
    load_use    = 1'b0;
    branch      = 1'b0;

    // Everything is held low while reset is asserted, even though the logic is combinational.
    if (rst) begin
      dmem_req    = in_wait | mem_op;
      dmem_we     = dmem_req & ex_is_store;
      access_done = dmem_req & dmem_ready;
      timeout     = in_wait & ~dmem_ready & (wait_cnt_q == LAST_WAIT);
      mem_stall   = dmem_req & ~dmem_ready & ~timeout;
      raw_hit     = (id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                    (id_uses_rs2 & (id_rs2_addr == ex_rd_addr));
      // A store flag overrides a simultaneous load flag, so such an access never makes a bubble.
      load_use    = access_done & ex_is_load & ~ex_is_store & (ex_rd_addr != 5'd0) & raw_hit;
      branch      = ~in_wait & ex_valid & ex_take_branch & ~mem_op;
    end

    stall_ex     = mem_stall;
    stall_if     = mem_stall | load_use;
    stall_id     = mem_stall | load_use;
    flush_id     = branch;
    flush_ex     = branch | load_use;
    mem_fault    = timeout;
    stall_cycles = stall_cycles_q;
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;

    if (mem_stall | load_use) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (access_done | timeout) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
